// File: rtl/fetch_unit_pkg.sv
// Shared fetch-stage constants: RV32 opcodes, the IF/ID bubble word and
// branch-history counter geometry, plus immediate decoders used by predecode.
package fetch_unit_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [6:0]  OPC_JAL    = 7'b1101111;
    localparam logic [6:0]  OPC_JALR   = 7'b1100111;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    localparam int               CTR_W     = 2;
    localparam logic [CTR_W-1:0] CTR_RESET = 2'b01;
    localparam logic [CTR_W-1:0] CTR_MAX   = 2'b11;

    function automatic logic [31:0] b_imm(input logic [31:0] w);
        return {{20{w[31]}}, w[7], w[30:25], w[11:8], 1'b0};
    endfunction

    function automatic logic [31:0] j_imm(input logic [31:0] w);
        return {{12{w[31]}}, w[19:12], w[20], w[30:21], 1'b0};
    endfunction

endpackage

// File: rtl/fetch_unit_bht.sv
// Branch history table of 2-bit saturating counters; only built when
// FETCH_BHT_EN is defined. Reads return the value before this edge's update.
`ifdef FETCH_BHT_EN
module fetch_unit_bht
    import fetch_unit_pkg::*;
#(
    parameter int ENTRIES = 16,
    parameter int IDX_W   = $clog2(ENTRIES)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic [IDX_W-1:0] rd_idx,
    output logic             rd_taken,
    input  logic             upd_valid,
    input  logic [IDX_W-1:0] upd_idx,
    input  logic             upd_taken
);

    logic [CTR_W-1:0] ctr_q [ENTRIES];
    logic [CTR_W-1:0] ctr_d [ENTRIES];
    logic [CTR_W-1:0] upd_ctr;

    always_comb begin
        ctr_d   = ctr_q;
        upd_ctr = ctr_q[upd_idx];
        if (upd_valid) begin
            if (upd_taken && (upd_ctr != CTR_MAX)) begin
                ctr_d[upd_idx] = upd_ctr + 1'b1;
            end else if (!upd_taken && (upd_ctr != '0)) begin
                ctr_d[upd_idx] = upd_ctr - 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < ENTRIES; i++) begin
                ctr_q[i] <= CTR_RESET;
            end
        end else begin
            ctr_q <= ctr_d;
        end
    end

    assign rd_taken = ctr_q[rd_idx][CTR_W-1];

endmodule
`endif

// File: rtl/fetch_unit.sv
// Instruction fetch with predecode-based next-PC prediction. Define
// FETCH_BHT_EN for a counter-table predictor; otherwise backward branches are taken.
module fetch_unit
    import fetch_unit_pkg::*;
#(
    parameter logic [31:0] RESET_PC    = 32'h0000_0000,
    parameter int          BHT_ENTRIES = 16
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        stall,
    input  logic        redirect,
    input  logic [31:0] redirect_pc,
    input  logic        bru_valid,
    input  logic [31:0] bru_pc,
    input  logic        bru_taken,
    output logic [31:0] imem_addr,
    input  logic [31:0] imem_rdata,
    output logic [31:0] code_IM,
    output logic [31:0] PC,
    output logic        prediction,
    output logic        if_id_clear
);

    localparam int IDX_W = $clog2(BHT_ENTRIES);

    logic [31:0] pc_q;
    logic [31:0] pc_d;
    logic [6:0]  opcode;
    logic        is_br;
    logic        is_jal;
    logic        br_taken;
    logic [31:0] b_off;
    logic [31:0] j_off;
    logic [31:0] imm;

    assign opcode = imem_rdata[6:0];
    assign is_br  = (opcode == OPC_BRANCH);
    assign is_jal = (opcode == OPC_JAL);
    assign b_off  = b_imm(imem_rdata);
    assign j_off  = j_imm(imem_rdata);
    assign imm    = is_jal ? j_off : b_off;

`ifdef FETCH_BHT_EN
    fetch_unit_bht #(
        .ENTRIES (BHT_ENTRIES),
        .IDX_W   (IDX_W)
    ) u_bht (
        .clk       (clk),
        .reset     (reset),
        .rd_idx    (pc_q[IDX_W+1:2]),
        .rd_taken  (br_taken),
        .upd_valid (bru_valid),
        .upd_idx   (bru_pc[IDX_W+1:2]),
        .upd_taken (bru_taken)
    );

    logic unused_bru_pc;
    assign unused_bru_pc = ^{bru_pc[31:IDX_W+2], bru_pc[1:0]};
`else
    // Static predictor: a negative offset means a loop back-edge.
    assign br_taken = b_off[31];

    logic unused_bru;
    assign unused_bru = ^{bru_valid, bru_pc, bru_taken};
`endif

    assign prediction  = !redirect && (is_jal || (is_br && br_taken));
    assign if_id_clear = redirect;
    assign imem_addr   = pc_q;
    assign PC          = pc_q;
    assign code_IM     = imem_rdata;

    always_comb begin
        pc_d = pc_q + 32'd4;
        if (redirect) begin
            pc_d = {redirect_pc[31:2], 2'b00};
        end else if (stall) begin
            pc_d = pc_q;
        end else if (prediction) begin
            pc_d = pc_q + imm;
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc_q <= RESET_PC;
        end else begin
            pc_q <= pc_d;
        end
    end

endmodule

// File: tb/tb_fetch_unit.sv
// Self-checking bench for fetch_unit: directed scenarios with literal
// expectations plus randomized traffic compared against a behavioural model.
`timescale 1ns/1ps
module tb_fetch_unit;

    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam int          ENTRIES  = 16;
    localparam logic [31:0] NOP      = 32'h0000_0013;
    localparam logic [31:0] JAL16    = 32'h0100_006F;
    localparam logic [31:0] BR_M8    = 32'hFE00_0CE3;
    localparam logic [31:0] BR_P8    = 32'h0000_0463;

    logic        clk = 1'b0;
    logic        reset, stall, redirect, bru_valid, bru_taken;
    logic [31:0] redirect_pc, bru_pc;
    logic [31:0] imem_addr, imem_rdata, code_IM, PC;
    logic        prediction, if_id_clear;

    logic        use_mem;
    logic [31:0] forced_word;
    logic [31:0] mem [256];

    int          total = 0;
    int          bad   = 0;
    int          ctr_m [ENTRIES];
    logic [31:0] m_pc;

    always #5 clk = ~clk;

    assign imem_rdata = use_mem ? mem[imem_addr[9:2]] : forced_word;

    fetch_unit #(.RESET_PC(RESET_PC), .BHT_ENTRIES(ENTRIES)) dut (
        .clk         (clk),
        .reset       (reset),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .bru_valid   (bru_valid),
        .bru_pc      (bru_pc),
        .bru_taken   (bru_taken),
        .imem_addr   (imem_addr),
        .imem_rdata  (imem_rdata),
        .code_IM     (code_IM),
        .PC          (PC),
        .prediction  (prediction),
        .if_id_clear (if_id_clear)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int imm_of(input logic [31:0] w, input bit jal);
        logic signed [12:0] b;
        logic signed [20:0] j;
        b = {w[31], w[7], w[30:25], w[11:8], 1'b0};
        j = {w[31], w[19:12], w[20], w[30:21], 1'b0};
        return jal ? int'(j) : int'(b);
    endfunction

    function automatic logic [31:0] enc_b(input int off);
        logic [12:0] i;
        i = off[12:0];
        return {i[12], i[10:5], 5'($urandom), 5'($urandom), 3'b000, i[4:1], i[11], 7'h63};
    endfunction

    function automatic logic [31:0] enc_j(input int off);
        logic [20:0] i;
        i = off[20:0];
        return {i[20], i[10:1], i[11], i[19:12], 5'($urandom), 7'h6F};
    endfunction

    // Reference model: evaluated once per cycle after the inputs settle.
    always @(negedge clk) begin : cmp
        logic [31:0] w, npc;
        bit          is_j, is_b, pr;
        int          imm, idx;
        #2;
        if (!reset) begin
            m_pc = RESET_PC;
            for (int i = 0; i < ENTRIES; i++) ctr_m[i] = 1;
        end
        w    = use_mem ? mem[m_pc[9:2]] : forced_word;
        is_j = (w[6:0] == 7'h6F);
        is_b = (w[6:0] == 7'h63);
        imm  = imm_of(w, is_j);
        idx  = int'((m_pc / 4) % ENTRIES);
`ifdef FETCH_BHT_EN
        pr = is_j || (is_b && ctr_m[idx] >= 2);
`else
        pr = is_j || (is_b && imm < 0);
`endif
        if (redirect) pr = 1'b0;
        chk("cmp_pc",   PC,          m_pc);
        chk("cmp_addr", imem_addr,   m_pc);
        chk("cmp_code", code_IM,     w);
        chk("cmp_pred", prediction,  pr);
        chk("cmp_clr",  if_id_clear, redirect);
        if (reset) begin
            if (redirect)  npc = redirect_pc & ~32'h3;
            else if (stall) npc = m_pc;
            else if (pr)   npc = m_pc + 32'(imm);
            else           npc = m_pc + 32'd4;
`ifdef FETCH_BHT_EN
            if (bru_valid) begin
                idx = int'((bru_pc / 4) % ENTRIES);
                if (bru_taken) ctr_m[idx] = (ctr_m[idx] == 3) ? 3 : ctr_m[idx] + 1;
                else           ctr_m[idx] = (ctr_m[idx] == 0) ? 0 : ctr_m[idx] - 1;
            end
`endif
            m_pc = npc;
        end
    end

    task automatic goto(input logic [31:0] a);
        @(negedge clk);
        redirect = 1'b1; redirect_pc = a; stall = 1'b0; bru_valid = 1'b0;
        @(negedge clk);
        redirect = 1'b0;
    endtask

`ifdef FETCH_BHT_EN
    task automatic train(input logic [31:0] a, input int n, input bit taken);
        goto(32'h44);
        stall = 1'b1; bru_valid = 1'b1; bru_pc = a; bru_taken = taken;
        repeat (n) @(negedge clk);
        bru_valid = 1'b0; stall = 1'b0;
    endtask
`endif

    initial begin
        reset = 1'b0; stall = 1'b0; redirect = 1'b0; redirect_pc = '0;
        bru_valid = 1'b0; bru_pc = '0; bru_taken = 1'b0;
        use_mem = 1'b0; forced_word = NOP;
        for (int i = 0; i < 256; i++) mem[i] = NOP;

        @(negedge clk); #3;
        chk("rst_pc", PC, RESET_PC);
        chk("rst_pred", prediction, 1'b0);
        @(negedge clk); reset = 1'b1; #3;
        chk("rel_pc0", PC, 32'h0);
        for (int k = 1; k <= 3; k++) begin
            @(negedge clk); #3;
            chk("seq_pc", PC, 32'(4 * k));
            chk("seq_pred", prediction, 1'b0);
        end

        @(negedge clk); redirect = 1'b1; redirect_pc = 32'h20; #3;
        chk("redir_clr", if_id_clear, 1'b1);
        @(negedge clk); redirect = 1'b0; forced_word = JAL16; #3;
        chk("jal_pc", PC, 32'h20);
        chk("jal_pred", prediction, 1'b1);
        @(negedge clk); forced_word = NOP; #3;
        chk("jal_next", PC, 32'h30);

        goto(32'h40);
        stall = 1'b1;
        repeat (3) begin
            #3; chk("stall_pc", PC, 32'h40);
            @(negedge clk);
        end
        forced_word = JAL16; redirect = 1'b1; redirect_pc = 32'h103; #3;
        chk("stall_redir_clr", if_id_clear, 1'b1);
        chk("stall_redir_pred", prediction, 1'b0);
        @(negedge clk); redirect = 1'b0; stall = 1'b0; forced_word = NOP; #3;
        chk("stall_redir_pc", PC, 32'h100);

        goto(32'hFFFF_FFFC); #3;
        chk("wrap_top", PC, 32'hFFFF_FFFC);
        @(negedge clk); #3;
        chk("wrap_zero", PC, 32'h0);

        goto(32'h50); forced_word = BR_M8; #3;
`ifdef FETCH_BHT_EN
        chk("bwd_pred", prediction, 1'b0);
        @(negedge clk); forced_word = NOP; #3;
        chk("bwd_next", PC, 32'h54);
`else
        chk("bwd_pred", prediction, 1'b1);
        @(negedge clk); forced_word = NOP; #3;
        chk("bwd_next", PC, 32'h48);
`endif
        goto(32'h50); forced_word = BR_P8; #3;
        chk("fwd_pred", prediction, 1'b0);
        @(negedge clk); forced_word = NOP; #3;
        chk("fwd_next", PC, 32'h54);

`ifdef FETCH_BHT_EN
        train(32'h80, 2, 1'b1);
        goto(32'h80); forced_word = BR_P8; #3;
        chk("bht_taken_pred", prediction, 1'b1);
        @(negedge clk); forced_word = NOP; #3;
        chk("bht_taken_next", PC, 32'h88);
        train(32'h80, 3, 1'b0);
        goto(32'h80); forced_word = BR_P8; #3;
        chk("bht_nt_pred", prediction, 1'b0);
        @(negedge clk); forced_word = NOP; #3;
        chk("bht_nt_next", PC, 32'h84);
        train(32'h80, 1, 1'b0);
        train(32'h80, 2, 1'b1);
        goto(32'h80); forced_word = BR_P8; #3;
        chk("bht_sat_pred", prediction, 1'b1);
        @(negedge clk); forced_word = NOP;

        goto(32'h90); forced_word = BR_P8;
        stall = 1'b1; bru_valid = 1'b1; bru_pc = 32'h90; bru_taken = 1'b1; #3;
        chk("same_idx_old", prediction, 1'b0);
        @(negedge clk); bru_valid = 1'b0; #3;
        chk("same_idx_new", prediction, 1'b1);
        @(negedge clk); stall = 1'b0; forced_word = NOP;
`endif

        @(negedge clk); reset = 1'b0; redirect = 1'b1; redirect_pc = 32'h200; #3;
        chk("rst_redir_pc", PC, RESET_PC);
        chk("rst_redir_clr", if_id_clear, 1'b1);
        @(negedge clk); reset = 1'b1; #3;
        chk("rst_rel_pc", PC, RESET_PC);
        @(negedge clk); redirect = 1'b0; #3;
        chk("rst_rel_redir", PC, 32'h200);

        for (int i = 0; i < 256; i++) begin
            case ($urandom_range(0, 9))
                0, 1, 2, 3: mem[i] = {25'($urandom), 7'h13};
                4, 5, 6:    mem[i] = enc_b(4 * (int'($urandom_range(0, 32)) - 16));
                7:          mem[i] = enc_j(4 * (int'($urandom_range(0, 32)) - 16));
                8:          mem[i] = {25'($urandom), 7'h67};
                default:    mem[i] = $urandom;
            endcase
        end
        @(negedge clk); use_mem = 1'b1;
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            stall       = ($urandom_range(0, 4) == 0);
            redirect    = ($urandom_range(0, 11) == 0);
            redirect_pc = ($urandom_range(0, 19) == 0) ? $urandom : ($urandom & 32'h3FF);
            bru_valid   = ($urandom_range(0, 2) == 0);
            bru_pc      = $urandom & 32'hFF;
            bru_taken   = $urandom_range(0, 1) == 1;
        end

        @(negedge clk);
        stall = 1'b0; redirect = 1'b0; bru_valid = 1'b0;
        @(negedge clk); #3;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
